// File: rtl/cnu_minsum_serial_pkg.sv
// ============================================================================
// Package : ldpc_pkg
// Purpose : LLR format and saturation limits shared by the LDPC datapath
//           stages, plus the state encoding of the serial check node.
// Items   : W        - LLR width, signed two's complement
//           LLR_MAX  - largest representable LLR,  2^(W-1)-1
//           LLR_MIN  - smallest representable LLR, -2^(W-1)
//           cnu_state_t - COLLECT (absorbing a row) / EMIT (draining a row)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ldpc_pkg;

  localparam int W = 6;

  localparam logic signed [W-1:0] LLR_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] LLR_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } cnu_state_t;

endpackage

`default_nettype wire

// File: rtl/cnu_minsum_serial_if.sv
// ============================================================================
// Interface: cnu_minsum_serial_if
// Purpose  : Input and output valid/ready message streams of the serial
//            check node unit.
// Signals  : in_valid/in_ready/in_msg     - variable-to-check LLR stream
//            out_valid/out_ready/out_msg  - check-to-variable LLR stream
//            out_last                     - marks final message of a row
// Modports : master - stream source/sink side (testbench, upstream logic)
//            slave  - the check node itself
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnu_minsum_serial_if #(
  parameter int W = ldpc_pkg::W
);

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_msg;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_msg;
  logic                out_last;

  modport master (
    output in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_msg, out_last
  );

  modport slave (
    input  in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_msg, out_last
  );

endinterface

`default_nettype wire

// File: rtl/cnu_minsum_serial_abs.sv
// ============================================================================
// Module  : llr_abs_sat
// Purpose : Combinational saturated magnitude of a signed LLR. The most
//           negative code has no positive counterpart and maps to the
//           largest magnitude instead of wrapping.
// Ports   : llr  in  W    signed LLR
//           mag  out W-1  unsigned saturated magnitude
//           sign out 1    sign bit of llr (zero counts as positive)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module llr_abs_sat
  import ldpc_pkg::*;
#(
  parameter int W = ldpc_pkg::W
) (
  input  wire logic signed [W-1:0] llr,
  output logic         [W-2:0]     mag,
  output logic                     sign
);

  logic         w_is_min;
  logic [W-2:0] w_neg_mag;

  // Low W-1 bits of -llr only depend on the low W-1 bits of llr.
  assign w_is_min  = llr[W-1] && (llr[W-2:0] == '0);
  assign w_neg_mag = ~llr[W-2:0] + {{(W-2){1'b0}}, 1'b1};

  always_comb begin
    sign = llr[W-1];
    if (w_is_min) begin
      mag = '1;
    end else if (llr[W-1]) begin
      mag = w_neg_mag;
    end else begin
      mag = llr[W-2:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/cnu_minsum_serial.sv
// ============================================================================
// Module  : cnu_minsum_serial
// Purpose : Serial offset-min-sum check node. Absorbs the DEG
//           variable-to-check LLRs of one parity row (one per accept),
//           tracking the two smallest magnitudes, the position of the
//           smallest and the sign parity, then emits DEG check-to-variable
//           messages with the offset applied and clamped at zero.
// Ports   : clk  in  clock, rising edge
//           rst  in  synchronous active-high reset
//           bus  slave modport of cnu_minsum_serial_if
//                (in_valid/in_ready/in_msg, out_valid/out_ready/out_msg,
//                 out_last)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cnu_minsum_serial
  import ldpc_pkg::*;
#(
  parameter int W      = ldpc_pkg::W,
  parameter int DEG    = 6,
  parameter int IDXW   = 3,
  parameter int OFFSET = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  cnu_minsum_serial_if.slave bus
);

  localparam logic [W-2:0]    c_mag_max  = '1;
  localparam logic [W-2:0]    c_offset   = (W-1)'(OFFSET);
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(DEG-1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  cnu_state_t r_state;
  cnu_state_t w_state_nxt;

  logic [IDXW-1:0]     r_cnt;
  logic [W-2:0]        r_min1;
  logic [W-2:0]        r_min2;
  logic [IDXW-1:0]     r_min_idx;
  logic [DEG-1:0]      r_sign_vec;
  logic                r_sign_tot;

  logic                r_out_valid;
  logic signed [W-1:0] r_out_msg;
  logic                r_out_last;

  logic [W-2:0]        w_in_mag;
  logic                w_in_sign;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_row_full;
  logic                w_out_fire;
  logic                w_row_done;

  logic [W-2:0]        w_min1_nxt;
  logic [W-2:0]        w_min2_nxt;
  logic [IDXW-1:0]     w_min_idx_nxt;
  logic [DEG-1:0]      w_sign_vec_nxt;
  logic                w_sign_tot_nxt;

  logic [IDXW-1:0]     w_k;
  logic [W-2:0]        w_m;
  logic [W-2:0]        w_m_off;
  logic                w_s;
  logic signed [W-1:0] w_out_msg_nxt;
  logic                w_out_last_nxt;

  // --------------------------------------------------------------------------
  // Input magnitude / sign
  // --------------------------------------------------------------------------
  llr_abs_sat #(
    .W (W)
  ) u_abs (
    .llr  (bus.in_msg),
    .mag  (w_in_mag),
    .sign (w_in_sign)
  );

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_row_full = w_accept && (r_cnt == c_last_idx);
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_row_done = w_out_fire && r_out_last;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_row_full) w_state_nxt = EMIT;
      EMIT:    if (w_row_done) w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready = (r_state == COLLECT) && !rst;
    // Index of the message to load next: output 0 when the row completes,
    // otherwise the successor of the one currently presented. The last
    // index has no successor; its value is then never used.
    if ((r_state == EMIT) && (r_cnt != c_last_idx)) begin
      w_k = r_cnt + IDXW'(1);
    end else begin
      w_k = '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_msg   = r_out_msg;
  assign bus.out_last  = r_out_last;

  // --------------------------------------------------------------------------
  // Running row statistics including the input being accepted this cycle.
  // Outside an accept these equal the registered values, so the emit path
  // can use them in both states and the first output of a row already sees
  // the DEG-th input.
  // --------------------------------------------------------------------------
  always_comb begin
    w_min1_nxt     = r_min1;
    w_min2_nxt     = r_min2;
    w_min_idx_nxt  = r_min_idx;
    w_sign_vec_nxt = r_sign_vec;
    w_sign_tot_nxt = r_sign_tot;
    if (w_accept) begin
      w_sign_vec_nxt[r_cnt] = w_in_sign;
      w_sign_tot_nxt        = r_sign_tot ^ w_in_sign;
      // Strict compares: a tie with min1 lands in min2 and min_idx keeps
      // the first occurrence.
      if (w_in_mag < r_min1) begin
        w_min2_nxt    = r_min1;
        w_min1_nxt    = w_in_mag;
        w_min_idx_nxt = r_cnt;
      end else if (w_in_mag < r_min2) begin
        w_min2_nxt = w_in_mag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Check-to-variable message for index w_k
  // --------------------------------------------------------------------------
  always_comb begin
    w_m            = (w_k == w_min_idx_nxt) ? w_min2_nxt : w_min1_nxt;
    // Offset clamps at zero rather than wrapping into a large magnitude.
    w_m_off        = (w_m > c_offset) ? (w_m - c_offset) : '0;
    w_s            = w_sign_tot_nxt ^ w_sign_vec_nxt[w_k];
    w_out_msg_nxt  = w_s ? -$signed({1'b0, w_m_off}) : $signed({1'b0, w_m_off});
    w_out_last_nxt = (w_k == c_last_idx);
  end

  // --------------------------------------------------------------------------
  // Datapath registers. Finishing a row restores exactly the reset values.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || w_row_done) begin
      r_cnt       <= '0;
      r_min1      <= c_mag_max;
      r_min2      <= c_mag_max;
      r_min_idx   <= '0;
      r_sign_vec  <= '0;
      r_sign_tot  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_msg   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_min1     <= w_min1_nxt;
      r_min2     <= w_min2_nxt;
      r_min_idx  <= w_min_idx_nxt;
      r_sign_vec <= w_sign_vec_nxt;
      r_sign_tot <= w_sign_tot_nxt;
      if (w_row_full) begin
        r_cnt       <= '0;
        r_out_valid <= 1'b1;
        r_out_msg   <= w_out_msg_nxt;
        r_out_last  <= w_out_last_nxt;
      end else begin
        r_cnt <= r_cnt + IDXW'(1);
      end
    end else if (w_out_fire) begin
      r_cnt      <= r_cnt + IDXW'(1);
      r_out_msg  <= w_out_msg_nxt;
      r_out_last <= w_out_last_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cnu_minsum_serial.sv
// ============================================================================
// Module  : tb_cnu_minsum_serial
// Purpose : Self-checking bench for cnu_minsum_serial. A row model pushes
//           the expected messages into a queue; a monitor pops and compares
//           on every output handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cnu_minsum_serial;
  import ldpc_pkg::*;

  localparam int DEG    = 6;
  localparam int IDXW   = 3;
  localparam int OFFSET = 1;

  typedef struct {
    int msg;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cnu_minsum_serial_if #(.W(W)) bus ();

  cnu_minsum_serial #(
    .W      (W),
    .DEG    (DEG),
    .IDXW   (IDXW),
    .OFFSET (OFFSET)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  int   stall_left = 0;
  int   row_outs = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference row model: straight from the min-sum rule.
  task automatic expect_row(input int v[DEG]);
    int mag[DEG];
    bit neg[DEG];
    bit par;
    int mn1, mn2, idx, m;
    exp_t e;
    par = 1'b0;
    for (int i = 0; i < DEG; i++) begin
      neg[i] = (v[i] < 0);
      mag[i] = neg[i] ? -v[i] : v[i];
      if (mag[i] > int'(LLR_MAX)) mag[i] = int'(LLR_MAX);
      par ^= neg[i];
    end
    mn1 = 1000;
    idx = 0;
    for (int i = 0; i < DEG; i++) begin
      if (mag[i] < mn1) begin
        mn1 = mag[i];
        idx = i;
      end
    end
    mn2 = 1000;
    for (int i = 0; i < DEG; i++) begin
      if (i != idx && mag[i] < mn2) mn2 = mag[i];
    end
    for (int k = 0; k < DEG; k++) begin
      m = (k == idx) ? mn2 : mn1;
      m = m - OFFSET;
      if (m < 0) m = 0;
      e.msg  = (par ^ neg[k]) ? -m : m;
      e.last = (k == DEG - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+#1 or later in the cycle; returns at posedge+#1.
  task automatic send(input int v, input bit gap, input bit last);
    int guard;
    bit acc;
    if (gap) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_msg   = v[W-1:0];
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      check("in_accept_timeout", 0, 1);
    end else if (last) begin
      check("latency_out_valid", int'(bus.out_valid), 1);
      check("in_ready_in_emit", int'(bus.in_ready), 0);
    end
  endtask

  task automatic run_row(input int v[DEG], input bit gaps);
    expect_row(v);
    row_outs   = 0;
    stall_left = 3;
    for (int i = 0; i < DEG; i++) send(v[i], gaps, i == DEG - 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 1000) check("drain_timeout", 0, 1);
  endtask

  // Output ready driver.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (bus.out_valid && row_outs == 1 && stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit   stalled;
    bit   chk_after_last;
    int   hold_msg;
    bit   hold_last;
    exp_t e;
    stalled        = 1'b0;
    chk_after_last = 1'b0;
    hold_msg       = 0;
    hold_last      = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled        = 1'b0;
        chk_after_last = 1'b0;
      end else begin
        if (chk_after_last) begin
          check("in_ready_after_last", int'(bus.in_ready), 1);
          check("out_valid_after_last", int'(bus.out_valid), 0);
          chk_after_last = 1'b0;
        end
        if (stalled) begin
          check("stall_hold_valid", int'(bus.out_valid), 1);
          check("stall_hold_msg", int'($signed(bus.out_msg)), hold_msg);
          check("stall_hold_last", int'(bus.out_last), int'(hold_last));
          stalled = 1'b0;
        end
        if (bus.out_valid) begin
          check("no_overlap_in_ready", int'(bus.in_ready), 0);
          if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_output", int'($signed(bus.out_msg)), 999);
            end else begin
              e = exp_q.pop_front();
              check("out_msg", int'($signed(bus.out_msg)), e.msg);
              check("out_last", int'(bus.out_last), int'(e.last));
              if (bus.out_last) chk_after_last = 1'b1;
            end
            row_outs++;
          end else begin
            stalled   = 1'b1;
            hold_msg  = int'($signed(bus.out_msg));
            hold_last = bus.out_last;
          end
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int basic[DEG];
    int row[DEG];
    basic = '{5, -3, 7, 2, -8, 4};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_msg   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_msg", int'($signed(bus.out_msg)), 0);
    check("reset_out_last", int'(bus.out_last), 0);
    check("reset_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", int'(bus.in_ready), 1);

    // Directed rows, always ready.
    ready_mode = 0;
    run_row(basic, 1'b0);
    wait_idle();
    row = '{-32, -32, -32, -32, -32, -32};
    run_row(row, 1'b0);
    wait_idle();
    row = '{4, 4, 9, 9, 9, 9};
    run_row(row, 1'b0);
    wait_idle();
    row = '{0, 1, 5, 5, 5, 5};
    run_row(row, 1'b0);
    wait_idle();

    // Backpressure on the second output.
    ready_mode = 2;
    run_row(basic, 1'b0);
    wait_idle();
    ready_mode = 0;

    // Reset after three accepted inputs: the partial row must vanish.
    for (int i = 0; i < 3; i++) send(basic[i], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrow_reset_out_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    #1;
    check("midrow_reset_in_ready", int'(bus.in_ready), 1);
    run_row(basic, 1'b0);
    wait_idle();

    // Random rows with random input gaps and output backpressure; the
    // next row is offered while the previous one is still draining.
    ready_mode = 1;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < DEG; i++) row[i] = int'($urandom_range(0, 63)) - 32;
      run_row(row, 1'b1);
    end
    wait_idle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
